// File: rtl/mem_dump_reader_if.sv
// -----------------------------------------------------------------------------
// mem_dump_reader_if
// Bundles the two bus-like channels of the memory dump reader:
//   - memory read port : mem_rd_en / mem_addr out of the reader, mem_rd_data
//                        back in, valid exactly one cycle after mem_rd_en.
//   - dump stream      : dump_valid / dump_addr / dump_data / dump_last out of
//                        the reader, dump_ready back in.
// Modports:
//   master : the reader (drives read strobe/address and the dump beat)
//   slave  : the environment (memory model + dump consumer)
//
// Handshake rule for the dump stream: a beat transfers on every rising edge
// where dump_valid && dump_ready. Once dump_valid is high, dump_addr,
// dump_data and dump_last stay stable and dump_valid stays high until that
// transfer; the only exception is an abort, which may drop dump_valid
// without a transfer.
// -----------------------------------------------------------------------------
interface mem_dump_reader_if #(
   parameter int REG_WIDTH  = 8,
   parameter int ADDR_WIDTH = 16
);
   logic                  mem_rd_en;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [REG_WIDTH-1:0]  mem_rd_data;

   logic                  dump_valid;
   logic                  dump_ready;
   logic [ADDR_WIDTH-1:0] dump_addr;
   logic [REG_WIDTH-1:0]  dump_data;
   logic                  dump_last;

   modport master (
      output mem_rd_en, mem_addr,
      input  mem_rd_data,
      output dump_valid, dump_addr, dump_data, dump_last,
      input  dump_ready
   );

   modport slave (
      input  mem_rd_en, mem_addr,
      output mem_rd_data,
      input  dump_valid, dump_addr, dump_data, dump_last,
      output dump_ready
   );
endinterface

// File: rtl/mem_dump_reader.sv
// -----------------------------------------------------------------------------
// mem_dump_reader
// Sweeps an inclusive address range of the memory read port and streams each
// word out as one beat (address, data, last flag) on a valid/ready channel,
// keeping a running 16-bit checksum of the accepted data.
//
// Ports:
//   clk, reset_n           clock (rising edge) and asynchronous active-low reset
//   start                  one-cycle dump request, honoured only in IDLE
//   abort                  cancel an active dump (returns to IDLE next cycle)
//   start_addr, end_addr   inclusive range, sampled with start
//   bus (master)           memory read port and dump stream
//   busy                   high in every state except IDLE
//   done                   one-cycle pulse after the last beat is accepted
//   range_err              one-cycle pulse after a start with an illegal range
//   checksum               sum of accepted dump_data mod 2**16
//   dbg_state              current FSM state (encoding of state_t)
//
// One beat costs three cycles: ISSUE (read strobe), WAIT (capture read data),
// SEND (hold beat until accepted).
// -----------------------------------------------------------------------------
module mem_dump_reader #(
   parameter int REG_WIDTH  = 8,
   parameter int ADDR_WIDTH = 16,
   parameter int MEM_DEPTH  = 65536
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic                  abort,
   input  logic [ADDR_WIDTH-1:0] start_addr,
   input  logic [ADDR_WIDTH-1:0] end_addr,
   mem_dump_reader_if.master     bus,
   output logic                  busy,
   output logic                  done,
   output logic                  range_err,
   output logic [15:0]           checksum,
   output logic [2:0]            dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_WAIT  = 3'd2,
      S_SEND  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   // Depth held one bit wider than the address so MEM_DEPTH = 2**ADDR_WIDTH
   // is representable and every end_addr compares below it.
   localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(MEM_DEPTH);

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] cur_q, cur_d;
   logic [ADDR_WIDTH-1:0] last_q, last_d;
   logic [ADDR_WIDTH-1:0] dump_addr_q, dump_addr_d;
   logic [REG_WIDTH-1:0]  dump_data_q, dump_data_d;
   logic                  dump_last_q, dump_last_d;
   logic                  range_err_q, range_err_d;
   logic [15:0]           checksum_q, checksum_d;

   logic range_ok;
   logic accept;

   assign range_ok = (start_addr <= end_addr) && ({1'b0, end_addr} < DEPTH_W);
   assign accept   = (state_q == S_SEND) && bus.dump_ready;

   always_comb begin
      state_d     = state_q;
      cur_d       = cur_q;
      last_d      = last_q;
      dump_addr_d = dump_addr_q;
      dump_data_d = dump_data_q;
      dump_last_d = dump_last_q;
      range_err_d = 1'b0;
      checksum_d  = checksum_q;

      case (state_q)
         S_IDLE: begin
            // abort in the same cycle as start suppresses the start entirely
            if (start && !abort) begin
               if (range_ok) begin
                  cur_d      = start_addr;
                  last_d     = end_addr;
                  checksum_d = 16'h0000;
                  state_d    = S_ISSUE;
               end else begin
                  range_err_d = 1'b1;
               end
            end
         end
         S_ISSUE: state_d = S_WAIT;
         S_WAIT: begin
            dump_data_d = bus.mem_rd_data;
            dump_addr_d = cur_q;
            dump_last_d = (cur_q == last_q);
            state_d     = S_SEND;
         end
         S_SEND: begin
            if (accept) begin
               checksum_d = checksum_q + 16'(dump_data_q);
               if (dump_last_q) begin
                  state_d = S_DONE;
               end else begin
                  // only advanced below last, so end_addr at the top of the
                  // address space never wraps to zero
                  cur_d   = cur_q + 1'b1;
                  state_d = S_ISSUE;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (abort && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         cur_q       <= '0;
         last_q      <= '0;
         dump_addr_q <= '0;
         dump_data_q <= '0;
         dump_last_q <= 1'b0;
         range_err_q <= 1'b0;
         checksum_q  <= 16'h0000;
      end else begin
         state_q     <= state_d;
         cur_q       <= cur_d;
         last_q      <= last_d;
         dump_addr_q <= dump_addr_d;
         dump_data_q <= dump_data_d;
         dump_last_q <= dump_last_d;
         range_err_q <= range_err_d;
         checksum_q  <= checksum_d;
      end
   end

   // All outputs decode from registers, so reset clears them immediately.
   assign bus.mem_rd_en  = (state_q == S_ISSUE);
   assign bus.mem_addr   = cur_q;
   assign bus.dump_valid = (state_q == S_SEND);
   assign bus.dump_addr  = dump_addr_q;
   assign bus.dump_data  = dump_data_q;
   assign bus.dump_last  = dump_last_q;
   assign busy           = (state_q != S_IDLE);
   assign done           = (state_q == S_DONE);
   assign range_err      = range_err_q;
   assign checksum       = checksum_q;
   assign dbg_state      = state_q;

endmodule
